gb_clock_ctrl: RTL and testbench

- Generates the Game Boy core clock (gb_clk) by dividing the system clock.
- Sits directly downstream of the debug halt/step trigger block and consumes its one-cycle trigger pulse to halt and resume gb_clk.
- Also halts on a rising edge of the core's halt request.
- Stops only at a full-period boundary, so gb_clk never produces a runt pulse.
- Exports a rising-edge strobe and a gb_clk cycle counter for debug readout.

---
 rtl/gb_clock_ctrl_pkg.sv | 16 +
 rtl/gb_clk_divider.sv | 45 ++++
 rtl/gb_clock_ctrl.sv | 89 ++++++++
 tb/tb_gb_clock_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gb_clock_ctrl_pkg.sv
// Shared types and parameter checks for the Game Boy core clock controller.
// Covers the run/stop state encoding and the divider-ratio legality rule.
package gb_clock_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_STOPPING = 2'd1,
      ST_HALTED   = 2'd2
   } state_e;

   // The divider needs two equal phases, so the ratio must be even and at least 2.
   function automatic bit div_is_legal(input int div);
      return (div >= 2) && ((div % 2) == 0);
   endfunction

endpackage

// File: rtl/gb_clk_divider.sv
// Free-running divider for gb_clk: period DIV, high for the first DIV/2 clks.
// Held at phase 0 with gb_clk low whenever en is low.
module gb_clk_divider #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic gb_clk,
   output logic gb_clk_rise,
   output logic start,
   output logic wrap
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2);

   logic [CW-1:0] cnt;

   // start and wrap describe the edge about to happen, so the controller can act on it.
   assign start = en && (cnt == '0);
   assign wrap  = en && (cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         gb_clk      <= 1'b0;
         gb_clk_rise <= 1'b0;
      end else if (!en) begin
         cnt         <= '0;
         gb_clk      <= 1'b0;
         gb_clk_rise <= 1'b0;
      end else begin
         gb_clk_rise <= (cnt == '0);
         if (cnt == '0)
            gb_clk <= 1'b1;
         else if (cnt == HALF)
            gb_clk <= 1'b0;
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/gb_clock_ctrl.sv
// Game Boy core clock controller: divides clk, halts/resumes on debug trigger
// or core halt request, and stops only at a full-period boundary.
module gb_clock_ctrl
   import gb_clock_ctrl_pkg::*;
#(
   parameter int DIV          = 4,
   parameter int COUNT_W      = 32,
   parameter int START_HALTED = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               trigger,
   input  logic               halt,
   output logic               gb_clk,
   output logic               gb_clk_rise,
   output logic               running,
   output logic [COUNT_W-1:0] cycle_count
);

   localparam logic [1:0] S_RUN      = ST_RUN;
   localparam logic [1:0] S_STOPPING = ST_STOPPING;
   localparam logic [1:0] S_HALTED   = ST_HALTED;
   localparam logic [1:0] S_RESET    = (START_HALTED != 0) ? S_HALTED : S_RUN;

   if (!div_is_legal(DIV)) begin : g_div_check
      $error("gb_clock_ctrl: DIV must be even and >= 2");
   end

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       halt_q;
   logic       halt_edge;
   logic       period_start;
   logic       period_wrap;

   assign halt_edge = halt & ~halt_q;
   assign running   = (state == S_RUN) || (state == S_STOPPING);

   gb_clk_divider #(
      .DIV (DIV)
   ) u_div (
      .clk         (clk),
      .reset       (reset),
      .en          (running),
      .gb_clk      (gb_clk),
      .gb_clk_rise (gb_clk_rise),
      .start       (period_start),
      .wrap        (period_wrap)
   );

   // NOTE: default the next state first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN:
            if (trigger || halt_edge)
               state_nxt = S_STOPPING;
         // A trigger cancels the stop even on the final edge of the period.
         S_STOPPING:
            if (trigger)
               state_nxt = S_RUN;
            else if (period_wrap)
               state_nxt = S_HALTED;
         S_HALTED:
            if (trigger)
               state_nxt = S_RUN;
         default:
            state_nxt = S_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_RESET;
         halt_q      <= 1'b0;
         cycle_count <= '0;
      end else begin
         state  <= state_nxt;
         halt_q <= halt;
         if (period_start)
            cycle_count <= cycle_count + COUNT_W'(1);
      end
   end

   a_no_rise_when_halted : assert property (
      @(posedge clk) disable iff (reset) !(gb_clk_rise && (state == S_HALTED))
   );

endmodule

// File: tb/tb_gb_clock_ctrl.sv
// Self-checking bench for gb_clock_ctrl: directed scenarios plus random
// trigger/halt/reset traffic against a timeline model of gb_clk.
module tb_gb_clock_ctrl;

   localparam int DIV          = 4;
   localparam int COUNT_W      = 32;
   localparam int START_HALTED = 0;

   localparam int M_RUN  = 0;
   localparam int M_STOP = 1;
   localparam int M_HALT = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               trigger;
   logic               halt;
   logic               gb_clk;
   logic               gb_clk_rise;
   logic               running;
   logic [COUNT_W-1:0] cycle_count;

   int n_tests = 0;
   int n_fail  = 0;

   gb_clock_ctrl #(
      .DIV          (DIV),
      .COUNT_W      (COUNT_W),
      .START_HALTED (START_HALTED)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .trigger     (trigger),
      .halt        (halt),
      .gb_clk      (gb_clk),
      .gb_clk_rise (gb_clk_rise),
      .running     (running),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: while not halted, the gb_clk phase of edge e is (e - origin) mod DIV,
   // where origin is the edge at which the current run of periods began.
   longint     edge_idx = 0;
   longint     origin   = 0;
   int         m_mode   = M_RUN;
   bit         m_halt_q = 1'b0;
   bit         m_gb     = 1'b0;
   bit         m_rise   = 1'b0;
   logic [31:0] m_count = '0;
   bit         m_valid  = 1'b0;

   always @(posedge clk) begin
      bit hedge;
      bit last;
      int pos;
      edge_idx++;
      if (reset) begin
         m_mode   = (START_HALTED != 0) ? M_HALT : M_RUN;
         origin   = edge_idx + 1;
         m_gb     = 1'b0;
         m_rise   = 1'b0;
         m_count  = '0;
         m_halt_q = 1'b0;
         m_valid  = 1'b1;
      end else begin
         hedge    = halt && !m_halt_q;
         m_halt_q = halt;
         last     = 1'b0;
         if (m_mode != M_HALT) begin
            pos    = int'((edge_idx - origin) % DIV);
            m_rise = (pos == 0);
            m_gb   = (pos < DIV / 2);
            last   = (pos == DIV - 1);
            if (m_rise) m_count = m_count + 1;
         end else begin
            m_gb   = 1'b0;
            m_rise = 1'b0;
         end
         if (m_mode == M_RUN) begin
            if (trigger || hedge) m_mode = M_STOP;
         end else if (m_mode == M_STOP) begin
            if (trigger) m_mode = M_RUN;
            else if (last) m_mode = M_HALT;
         end else begin
            if (trigger) begin
               m_mode = M_RUN;
               origin = edge_idx + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("gb_clk",      32'(gb_clk),      32'(m_gb));
         check("gb_clk_rise", 32'(gb_clk_rise), 32'(m_rise));
         check("running",     32'(running),     32'(m_mode != M_HALT));
         check("cycle_count", cycle_count,      m_count);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      step(1);
      trigger = 1'b0;
   endtask

   // Align to the negedge right after a gb_clk rise; bounded by two periods.
   task automatic wait_rise();
      bit seen = 1'b0;
      for (int i = 0; i < 2 * DIV; i++) begin
         if (gb_clk_rise) begin
            seen = 1'b1;
            break;
         end
         step(1);
      end
      if (!seen) check("wait_rise_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat;
      reset   = 1'b1;
      trigger = 1'b0;
      halt    = 1'b0;
      step(2);
      check("reset_gb_clk", 32'(gb_clk), 32'd0);
      check("reset_count",  cycle_count, 32'd0);
      check("reset_running", 32'(running), 32'd1);
      reset = 1'b0;

      // Free run: gb_clk 1,1,0,0 and five rises in twenty clks.
      pat = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("pattern_gb_clk", 32'(gb_clk), 32'(pat[i]));
         check("pattern_rise",   32'(gb_clk_rise), 32'(i == 0));
      end
      step(16);
      check("count_after_20", cycle_count, 32'd5);

      // Trigger sampled on the cnt==1 edge: finish the period, then halt.
      step(1);
      pulse_trigger();
      check("stopping_gb_high", 32'(gb_clk), 32'd1);
      step(2);
      check("halted_running", 32'(running), 32'd0);
      check("halted_count",   cycle_count, 32'd6);
      step(5);
      check("halted_frozen",  cycle_count, 32'd6);
      check("halted_gb_low",  32'(gb_clk), 32'd0);

      // Resume then trigger in the 4th period: exactly four rises.
      pulse_trigger();
      check("resume_running", 32'(running), 32'd1);
      check("resume_no_rise", 32'(gb_clk_rise), 32'd0);
      step(1);
      check("resume_rise",    32'(gb_clk_rise), 32'd1);
      step(12);
      pulse_trigger();
      step(2);
      check("step_halted",    32'(running), 32'd0);
      check("step_count",     cycle_count, 32'd10);

      // Core halt level: one stop only, trigger resumes despite the level.
      pulse_trigger();
      halt = 1'b1;
      step(20);
      check("halt_level_stop", 32'(running), 32'd0);
      pulse_trigger();
      step(28);
      check("halt_level_no_rehalt", 32'(running), 32'd1);
      halt = 1'b0;
      step(1);

      // Cancel on the final edge of a stopping period: no gap in gb_clk.
      wait_rise();
      pulse_trigger();
      step(1);
      pulse_trigger();
      check("cancel_running", 32'(running), 32'd1);
      step(1);
      check("cancel_no_gap",  32'(gb_clk_rise), 32'd1);

      // Trigger and halt edge together while halted resume.
      pulse_trigger();
      step(4);
      check("pre_both_halted", 32'(running), 32'd0);
      halt = 1'b1;
      pulse_trigger();
      check("both_resume", 32'(running), 32'd1);
      halt = 1'b0;
      step(3);

      // Reset in STOPPING with gb_clk high.
      wait_rise();
      pulse_trigger();
      reset = 1'b1;
      step(1);
      check("midreset_gb_clk", 32'(gb_clk), 32'd0);
      check("midreset_count",  cycle_count, 32'd0);
      check("midreset_running", 32'(running), 32'd1);
      reset = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         trigger = ($urandom_range(15) == 0);
         if ($urandom_range(7) == 0) halt = ~halt;
         reset = ($urandom_range(499) == 0);
         step(1);
      end
      trigger = 1'b0;
      reset   = 1'b0;
      step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
